// File: rtl/warp_scheduler.sv
// Frame-level warp dispatcher: issues warp IDs 0..NUM_WARPS-1 round-robin to idle units,
// tracks per-unit busy state from done pulses and pulses frame_done when the frame drains.
module warp_scheduler #(
  parameter int unsigned NUM_UNITS     = 4,
  parameter int unsigned NUM_WARPS     = 16,
  parameter int unsigned WARP_ID_WIDTH = 8,
  parameter int unsigned CNT_WIDTH     = $clog2(NUM_WARPS + 1)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      frame_start,
  input  logic                                      pause,
  input  logic [NUM_UNITS-1:0]                      unit_done,
  output logic [NUM_UNITS-1:0]                      unit_enable,
  output logic [NUM_UNITS-1:0][WARP_ID_WIDTH-1:0]   unit_warp_id,
  output logic [NUM_UNITS-1:0]                      unit_warp_valid,
  output logic                                      frame_busy,
  output logic                                      frame_done
);

  localparam int unsigned PtrWidth = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [CNT_WIDTH-1:0] WarpsTotal = CNT_WIDTH'(NUM_WARPS);

  typedef enum logic [1:0] {
    StIdle,
    StDispatch,
    StDrain,
    StDone
  } state_e;

  state_e                                  state_q, state_d;
  logic [CNT_WIDTH-1:0]                    issued_q, issued_d;
  logic [CNT_WIDTH-1:0]                    done_q, done_d;
  logic [PtrWidth-1:0]                     rr_q, rr_d;
  logic [NUM_UNITS-1:0]                    busy_q, busy_d;
  logic [NUM_UNITS-1:0]                    valid_q, valid_d;
  logic [NUM_UNITS-1:0][WARP_ID_WIDTH-1:0] warp_id_q, warp_id_d;
  logic                                    frame_busy_q, frame_busy_d;
  logic                                    frame_done_q, frame_done_d;

  logic [NUM_UNITS-1:0] accepted;
  logic [CNT_WIDTH-1:0] accepted_cnt;
  logic                 grant_found;
  logic [PtrWidth-1:0]  grant_idx;
  logic                 can_issue;

  // Only a done on a busy unit counts; a done on an idle unit is dropped.
  assign accepted = unit_done & busy_q;

  always_comb begin
    accepted_cnt = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (accepted[i]) begin
        accepted_cnt = accepted_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // First idle unit scanning from rr_q; eligibility uses the registered busy vector so a
  // unit finishing this cycle cannot be reissued until the next one.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned off = 0; off < NUM_UNITS; off++) begin
      idx = (32'(rr_q) + off) % NUM_UNITS;
      if (!grant_found && !busy_q[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PtrWidth'(idx);
      end
    end
  end

  assign can_issue = (state_q == StDispatch) && !pause && (issued_q < WarpsTotal) && grant_found;

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    done_d    = done_q + accepted_cnt;
    rr_d      = rr_q;
    busy_d    = busy_q & ~accepted;
    valid_d   = '0;
    warp_id_d = warp_id_q;

    case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d  = StDispatch;
          issued_d = '0;
          done_d   = '0;
          rr_d     = '0;
        end
      end
      StDispatch: begin
        if (can_issue) begin
          warp_id_d[grant_idx] = WARP_ID_WIDTH'(issued_q);
          valid_d[grant_idx]   = 1'b1;
          busy_d[grant_idx]    = 1'b1;
          issued_d             = issued_q + CNT_WIDTH'(1);
          rr_d = (32'(grant_idx) == NUM_UNITS - 1) ? '0 : grant_idx + 1'b1;
        end
        if (issued_d == WarpsTotal) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (done_q == WarpsTotal) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    frame_busy_d = (state_d == StDispatch) || (state_d == StDrain);
    frame_done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      issued_q     <= '0;
      done_q       <= '0;
      rr_q         <= '0;
      busy_q       <= '0;
      valid_q      <= '0;
      warp_id_q    <= '0;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      issued_q     <= issued_d;
      done_q       <= done_d;
      rr_q         <= rr_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      warp_id_q    <= warp_id_d;
      frame_busy_q <= frame_busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign unit_enable     = busy_q;
  assign unit_warp_id    = warp_id_q;
  assign unit_warp_valid = valid_q;
  assign frame_busy      = frame_busy_q;
  assign frame_done      = frame_done_q;

endmodule

// File: doc/warp_scheduler.md
# warp_scheduler

Frame-level controller that sequences warp execution across a pool of `warp` compute units. On a frame start it issues warp IDs 0..NUM_WARPS-1 in order, one per cycle at most, to idle units chosen round-robin. It tracks per-unit busy state from completion pulses and signals frame completion once every issued warp has finished. It sits between the frame/command front end and the array of `warp` instances. It drives their `enable`, `warp_id` and `warp_data_valid` inputs.

## Interface
- NUM_UNITS, 4, number of `warp` units managed (≥1)
- NUM_WARPS, 16, warps per frame (≥1, ≤ 2^WARP_ID_WIDTH)
- WARP_ID_WIDTH, 8, width of warp ID
- CNT_WIDTH, $clog2(NUM_WARPS+1), width of issue/complete counters
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- frame_start  in  1  one-cycle request to begin a frame; ignored unless IDLE
- pause  in  1  while high, no new warp is issued; completions still accepted
- unit_done  in  [NUM_UNITS]  per-unit one-cycle pulse: the unit finished its current warp
- unit_enable  out  [NUM_UNITS]  per-unit busy flag; high from issue until the unit's done is accepted
- unit_warp_id  out  [NUM_UNITS][WARP_ID_WIDTH]  warp ID last issued to each unit; holds between issues
- unit_warp_valid  out  [NUM_UNITS]  one-cycle issue strobe; at most one bit high per cycle
- frame_busy  out  1  high in DISPATCH and DRAIN
- frame_done  out  1  one-cycle pulse when the frame completes

## Operation
- State machine, one-hot or encoded: IDLE, DISPATCH, DRAIN, DONE.
- IDLE → DISPATCH on frame_start. Clear issued_cnt, done_cnt and rr_ptr (to 0).
- DISPATCH: each cycle, if pause=0 and issued_cnt<NUM_WARPS and some unit has busy=0, issue to that unit.
  - Grant goes to the first idle unit scanning rr_ptr, rr_ptr+1, … modulo NUM_UNITS.
  - Issuing registers unit_warp_id[g]=issued_cnt, pulses unit_warp_valid[g], sets busy[g], increments issued_cnt and sets rr_ptr=(g+1) mod NUM_UNITS.
- DISPATCH → DRAIN when issued_cnt reaches NUM_WARPS.
- DRAIN → DONE when done_cnt reaches NUM_WARPS. DONE lasts one cycle, asserts frame_done, then returns to IDLE.
- Completion accepted in any state:
  - unit_done[i] with busy[i]=1 clears busy[i] and increments done_cnt.
  - unit_done[i] with busy[i]=0 is ignored.
  - Multiple simultaneous done bits are all accepted in the same cycle, so done_cnt may increase by up to NUM_UNITS.
- Eligibility uses the registered busy vector. A unit whose done arrives in cycle t is eligible for issue no earlier than cycle t+1. Issue and done never act on the same unit in the same cycle.
- frame_start while not IDLE is ignored, with no restart.
- Counters never wrap: issued_cnt ≤ NUM_WARPS and done_cnt ≤ issued_cnt by construction.

## Timing
- Reset values: state=IDLE, all busy/unit_enable=0, unit_warp_id=0, unit_warp_valid=0, frame_busy=0, frame_done=0, counters=0, rr_ptr=0.
- rst has priority over all inputs. Reset mid-frame drops all busy state and in-flight accounting, and no frame_done is produced.
- All outputs are registered.
- frame_start high at edge t → frame_busy high after edge t. The first unit_warp_valid (unit 0, ID 0) is high after edge t+1.
- Issue rate is at most 1 warp/cycle. With all units idle and pause=0, warps 0..NUM_UNITS-1 go to units 0..NUM_UNITS-1 on consecutive cycles.
- pause sampled high at edge k → no unit_warp_valid after edge k.
- Final done accepted at edge k, with done_cnt reaching NUM_WARPS → state DONE after edge k+1; frame_done high for that single cycle and frame_busy low in that same cycle.
- unit_enable[i] rises with unit_warp_valid[i] and falls the cycle after its accepted unit_done[i].

## Test plan
- Basic frame, NUM_UNITS=4, NUM_WARPS=16:
  - Stimulus: frame_start pulse; each unit pulses done 3 cycles after issue.
  - Required: IDs 0–15 issued exactly once; first four issues go to units 0,1,2,3 on consecutive cycles; one frame_done pulse; frame_busy drops.
- Out-of-order completion:
  - Stimulus: unit 2 finishes first, with units 0,1,3 still busy.
  - Required: next ID goes to unit 2 no earlier than the cycle after its done; rr_ptr advances to 3.
- Pause:
  - Stimulus: hold pause high for 10 cycles mid-DISPATCH, with done pulses arriving meanwhile.
  - Required: no unit_warp_valid during pause; done_cnt still increments; issuing resumes the cycle after pause drops.
- Spurious and late inputs:
  - Stimulus: unit_done on an idle unit.
  - Required: done_cnt unchanged.
  - Stimulus: frame_start during DRAIN.
  - Required: ignored; exactly one frame_done.
- Simultaneous completions:
  - Stimulus: all 4 units pulse done in the same cycle.
  - Required: done_cnt +4; all four units reissued over the next 4 cycles.
- Reset mid-frame:
  - Stimulus: assert rst after 7 issues.
  - Required: all outputs at reset values next cycle and no frame_done.
  - Stimulus: a new frame_start afterwards.
  - Required: restarts from ID 0 on unit 0.
